gerenciador_lanes: RTL and testbench
====================================

GERENCIADOR_LANES -- requirements
Module: gerenciador_lanes

Interface
REQ-001 Parameter N_LANES, default 3: number of note lanes served; legal range 1..8.
REQ-002 Parameter CMD_W, default 4: width of one lane command word.
REQ-003 Parameter LIST_DEPTH, default 16: number of command-list entries; power of two, at least 2; AW = log2(LIST_DEPTH).
REQ-004 Parameter SCORE_W, default 16: width of the score accumulator.
REQ-005 Parameter COMBO_W, default 6: width of the combo counter.
REQ-006 CLOCK_25  in  1: the single clock; all state changes on its rising edge.
REQ-007 reset  in  1: synchronous, active-high reset.
REQ-008 start  in  1: one-cycle pulse that starts or restarts a game.
REQ-009 fim_da_lista  in  AW+1: number of valid list entries; sampled on start only.
REQ-010 cmd_wr_en  in  1: list write strobe.
REQ-011 cmd_wr_addr  in  AW: list write address.
REQ-012 cmd_wr_data  in  CMD_W: list write data.
REQ-013 trocar  in  N_LANES: per-lane level request for the next command.
REQ-014 ponto  in  N_LANES: per-lane one-cycle hit pulse.
REQ-015 erro  in  N_LANES: per-lane one-cycle miss pulse.
REQ-016 prox_comando  out  CMD_W: command delivered with the current grant.
REQ-017 cmd_ack  out  N_LANES: one-hot, one-cycle grant to the lane receiving prox_comando.
REQ-018 score  out  SCORE_W: accumulated score.
REQ-019 combo  out  COMBO_W: current hit streak.
REQ-020 fim_de_jogo  out  1: game-over flag.
REQ-021 estado  out  2: FSM state; IDLE=0, PLAYING=1, GAME_OVER=2.

Function
REQ-022 FSM transitions:
- IDLE -> PLAYING on start when fim_da_lista != 0; start with fim_da_lista = 0 is ignored.
- PLAYING -> GAME_OVER on the cycle after the grant that delivers entry fim_da_lista-1.
- GAME_OVER -> PLAYING on start.
- No other transitions.
REQ-023 Each start that is acted on SHALL clear the read pointer, score, combo and round-robin pointer, and SHALL latch fim_da_lista (clamped to LIST_DEPTH).
REQ-024 cmd_wr_en SHALL write the list only in IDLE or GAME_OVER; writes during PLAYING are ignored.
REQ-025 In PLAYING, eligible requests SHALL be trocar & ~cmd_ack (the lane granted in the previous cycle is masked for one cycle).
REQ-026 Arbitration SHALL be round-robin: the search starts at the lane after the last granted lane, wrapping from N_LANES-1 to 0; after reset or start the last granted lane is N_LANES-1, so lane 0 has first priority.
REQ-027 Grant timing and content:
- Grants are registered: cmd_ack and prox_comando are valid in the cycle after the request is sampled.
- prox_comando = list[ptr] at grant time, then ptr increments.
- At most one grant per cycle.
REQ-028 When no grant is issued, cmd_ack SHALL be 0 and prox_comando SHALL hold its last value.
REQ-029 A lane that keeps trocar high after its ack is a new request and is eligible again two cycles after the ack.
REQ-030 Hits: h = popcount(ponto) is counted only in PLAYING; ponto and erro are ignored in IDLE and GAME_OVER.
REQ-031 Multiplier m = 1 + min(combo >> 3, 3), giving 1..4, computed from combo before the update.
REQ-032 Score update: score += h*m, saturating at 2^SCORE_W-1; visible one cycle after the pulse.
REQ-033 Combo update:
- If any erro bit is set, combo <= 0 in that cycle; the same cycle's hits still score with the old multiplier.
- Otherwise combo += h, saturating at 2^COMBO_W-1.
REQ-034 fim_de_jogo SHALL equal (estado == GAME_OVER), registered.

Reset
REQ-035 On reset the block SHALL enter IDLE, with:
- pointers = 0
- last grant = N_LANES-1
- score = 0
- combo = 0
- prox_comando = 0
- cmd_ack = 0
- fim_de_jogo = 0
REQ-036 The list contents SHALL be unaffected by reset.
REQ-037 Reset SHALL take priority over start, writes and pulses in the same cycle, including in the middle of a game.

Verification
REQ-038 Load list 1,2,3,4, then start with fim_da_lista = 4 and trocar = 3'b111 held -> cmd_ack sequence 001, 010, 100, 001 with prox_comando 1, 2, 3, 4; then fim_de_jogo = 1 and no further acks.
REQ-039 Send 8 single ponto pulses, then one more -> score 8 (m = 1) and combo 8; the ninth hit adds 2, giving score 10 and combo 9.
REQ-040 With combo = 9, ponto = 3'b011 and erro = 3'b100 in the same cycle -> score +4, combo = 0.
REQ-041 Assert cmd_wr_en during PLAYING -> list unchanged; after a restart via start, the original values are delivered.
REQ-042 Assert reset mid-game with score 10 -> next cycle estado = 0, score = 0, cmd_ack = 0; a start with fim_da_lista = 0 leaves estado = 0.
REQ-043 Preload score = 2^SCORE_W-2 with combo >= 24 and send one ponto -> score = 2^SCORE_W-1, saturated.

Source files
------------

// File: rtl/gerenciador_lanes.sv
// gerenciador_lanes: round-robin command dispatcher for N note lanes plus
// score/combo bookkeeping for one rhythm-game session.
module gerenciador_lanes #(
    parameter int N_LANES    = 3,
    parameter int CMD_W      = 4,
    parameter int LIST_DEPTH = 16,
    parameter int SCORE_W    = 16,
    parameter int COMBO_W    = 6,
    localparam int AW        = $clog2(LIST_DEPTH),
    localparam int LW        = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic               start,
    input  logic [AW:0]        fim_da_lista,
    input  logic               cmd_wr_en,
    input  logic [AW-1:0]      cmd_wr_addr,
    input  logic [CMD_W-1:0]   cmd_wr_data,
    input  logic [N_LANES-1:0] trocar,
    input  logic [N_LANES-1:0] ponto,
    input  logic [N_LANES-1:0] erro,
    output logic [CMD_W-1:0]   prox_comando,
    output logic [N_LANES-1:0] cmd_ack,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic               fim_de_jogo,
    output logic [1:0]         estado
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t             state;
    logic [CMD_W-1:0]   list_mem [LIST_DEPTH];
    logic [AW:0]        rd_ptr;
    logic [AW:0]        fim_len;
    logic [LW-1:0]      last_grant;

    logic [N_LANES-1:0] eligible;
    logic               grant_any;
    logic [LW-1:0]      grant_idx;
    logic [LW-1:0]      cand_idx;

    logic [3:0]         hits;
    logic [6:0]         gain;
    logic [SCORE_W-1:0] score_nxt;
    logic [COMBO_W-1:0] combo_nxt;

    function automatic logic [3:0] popcount(input logic [N_LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < N_LANES; i++)
            n = n + 4'(v[i]);
        return n;
    endfunction

    // Streak tiers of 8 hits raise the multiplier, capped at x4.
    function automatic logic [2:0] mult_of(input logic [COMBO_W-1:0] c);
        logic [COMBO_W-1:0] tier;
        tier = c >> 3;
        if (tier >= COMBO_W'(3))
            return 3'd4;
        return 3'(tier) + 3'd1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] acc,
                                                     input logic [6:0] add);
        logic [SCORE_W+7:0] sum;
        sum = {8'd0, acc} + (SCORE_W+8)'(add);
        if (sum[SCORE_W+7:SCORE_W] != '0)
            return '1;
        return sum[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_combo(input logic [COMBO_W-1:0] acc,
                                                     input logic [3:0] add);
        logic [COMBO_W+4:0] sum;
        sum = {5'd0, acc} + (COMBO_W+5)'(add);
        if (sum[COMBO_W+4:COMBO_W] != '0)
            return '1;
        return sum[COMBO_W-1:0];
    endfunction

    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        if (len > (AW+1)'(LIST_DEPTH))
            return (AW+1)'(LIST_DEPTH);
        return len;
    endfunction

    // Round-robin search starting one lane past the last grant; the lane
    // acked last cycle is masked so a held request cannot win back-to-back.
    always_comb begin
        eligible  = trocar & ~cmd_ack;
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand_idx  = '0;
        if (state == PLAYING && rd_ptr < fim_len) begin
            for (int i = 1; i <= N_LANES; i++) begin
                cand_idx = LW'((int'(last_grant) + i) % N_LANES);
                if (!grant_any && eligible[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        hits      = popcount(ponto);
        gain      = 7'(hits) * 7'(mult_of(combo));
        score_nxt = sat_score(score, gain);
        combo_nxt = (|erro) ? '0 : sat_combo(combo, hits);
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            fim_len      <= '0;
            last_grant   <= LW'(N_LANES - 1);
            score        <= '0;
            combo        <= '0;
            prox_comando <= '0;
            cmd_ack      <= '0;
            fim_de_jogo  <= 1'b0;
        end else begin
            cmd_ack <= '0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (start && fim_da_lista != '0) begin
                        state       <= PLAYING;
                        fim_de_jogo <= 1'b0;
                        rd_ptr      <= '0;
                        fim_len     <= clamp_len(fim_da_lista);
                        last_grant  <= LW'(N_LANES - 1);
                        score       <= '0;
                        combo       <= '0;
                    end
                end
                PLAYING: begin
                    // The last entry was granted on the previous edge.
                    if (rd_ptr >= fim_len) begin
                        state       <= GAME_OVER;
                        fim_de_jogo <= 1'b1;
                    end
                    if (grant_any) begin
                        cmd_ack      <= N_LANES'(1) << grant_idx;
                        prox_comando <= list_mem[rd_ptr[AW-1:0]];
                        rd_ptr       <= rd_ptr + 1'b1;
                        last_grant   <= grant_idx;
                    end
                    score <= score_nxt;
                    combo <= combo_nxt;
                end
                default: begin
                    state       <= IDLE;
                    fim_de_jogo <= 1'b0;
                end
            endcase
        end
    end

    // List storage keeps its contents across reset; only the write is gated.
    always_ff @(posedge CLOCK_25) begin
        if (!reset && cmd_wr_en && state != PLAYING)
            list_mem[cmd_wr_addr] <= cmd_wr_data;
    end

    assign estado = state;

endmodule

// File: tb/tb_gerenciador_lanes.sv
// Scoreboard bench for gerenciador_lanes: a per-cycle reference model feeds
// expected status and grants into queues that a monitor process drains.
`timescale 1ns/1ps
module tb_gerenciador_lanes;

    localparam int N    = 3;
    localparam int CW   = 4;
    localparam int LD   = 16;
    localparam int SW   = 16;
    localparam int KW   = 6;
    localparam int AW   = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int CMAX = (1 << KW) - 1;

    logic          CLOCK_25 = 1'b0;
    logic          reset, start, cmd_wr_en;
    logic [AW:0]   fim_da_lista;
    logic [AW-1:0] cmd_wr_addr;
    logic [CW-1:0] cmd_wr_data;
    logic [N-1:0]  trocar, ponto, erro;
    logic [CW-1:0] prox_comando;
    logic [N-1:0]  cmd_ack;
    logic [SW-1:0] score;
    logic [KW-1:0] combo;
    logic          fim_de_jogo;
    logic [1:0]    estado;

    gerenciador_lanes #(
        .N_LANES(N), .CMD_W(CW), .LIST_DEPTH(LD), .SCORE_W(SW), .COMBO_W(KW)
    ) dut (
        .CLOCK_25(CLOCK_25), .reset(reset), .start(start),
        .fim_da_lista(fim_da_lista), .cmd_wr_en(cmd_wr_en),
        .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .trocar(trocar), .ponto(ponto), .erro(erro),
        .prox_comando(prox_comando), .cmd_ack(cmd_ack), .score(score),
        .combo(combo), .fim_de_jogo(fim_de_jogo), .estado(estado)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    typedef struct { int st; int score; int combo; int ack; int prox; } stat_t;
    typedef struct { int lane; int cmd; } grant_t;
    stat_t  sq[$];
    grant_t gq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (game-level view)
    int m_st, m_ptr, m_len, m_last, m_score, m_combo, m_prev, m_prox;
    int m_list[LD];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the rules to the inputs currently driven; they take effect at the next edge.
    task automatic step();
        int g, h, mul, lane, fim;
        stat_t  s;
        grant_t gr;
        g = -1;
        if (reset) begin
            m_st = 0; m_ptr = 0; m_last = N - 1;
            m_score = 0; m_combo = 0; m_prox = 0;
        end else begin
            if (cmd_wr_en && m_st != 1) m_list[cmd_wr_addr] = int'(cmd_wr_data);
            if (m_st != 1) begin
                fim = int'(fim_da_lista);
                if (start && fim != 0) begin
                    m_st = 1; m_ptr = 0; m_len = (fim > LD) ? LD : fim;
                    m_score = 0; m_combo = 0; m_last = N - 1;
                end
            end else begin
                if (m_ptr >= m_len) m_st = 2;
                else begin
                    for (int k = 1; k <= N; k++) begin
                        lane = (m_last + k) % N;
                        if (g < 0 && trocar[lane] && lane != m_prev) g = lane;
                    end
                end
                if (g >= 0) begin
                    m_prox = m_list[m_ptr];
                    m_ptr++;
                    m_last = g;
                    gr.lane = g; gr.cmd = m_prox;
                    gq.push_back(gr);
                end
                h   = $countones(ponto);
                mul = 1 + (((m_combo / 8) > 3) ? 3 : (m_combo / 8));
                m_score = (m_score + h * mul > SMAX) ? SMAX : m_score + h * mul;
                if (erro != 0) m_combo = 0;
                else m_combo = (m_combo + h > CMAX) ? CMAX : m_combo + h;
            end
        end
        m_prev = g;
        s.st = m_st; s.score = m_score; s.combo = m_combo;
        s.ack = (g < 0) ? 0 : (1 << g); s.prox = m_prox;
        sq.push_back(s);
    endtask

    task automatic idle_in();
        reset = 0; start = 0; fim_da_lista = '0; cmd_wr_en = 0;
        cmd_wr_addr = '0; cmd_wr_data = '0; trocar = '0; ponto = '0; erro = '0;
    endtask

    task automatic next_cycle();
        @(negedge CLOCK_25);
        idle_in();
    endtask

    task automatic settle();
        next_cycle();
        step();
    endtask

    task automatic write_entry(input int a, input int d);
        next_cycle();
        cmd_wr_en = 1; cmd_wr_addr = AW'(a); cmd_wr_data = CW'(d);
        step();
    endtask

    task automatic do_start(input int fim);
        next_cycle();
        start = 1; fim_da_lista = (AW+1)'(fim);
        step();
    endtask

    task automatic hit(input int p, input int e);
        next_cycle();
        ponto = N'(p); erro = N'(e);
        step();
    endtask

    task automatic hold_trocar(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            trocar = '1;
            step();
        end
    endtask

    // Monitor: compares every cycle's status and each presented grant.
    initial begin
        stat_t  s;
        grant_t g;
        forever begin
            @(posedge CLOCK_25);
            #1;
            if (sq.size() == 0) begin
                check("status_queue_empty", 1, 0);
            end else begin
                s = sq.pop_front();
                check("estado", int'(estado), s.st);
                check("fim_de_jogo", int'(fim_de_jogo), (s.st == 2) ? 1 : 0);
                check("score", int'(score), s.score);
                check("combo", int'(combo), s.combo);
                check("cmd_ack", int'(cmd_ack), s.ack);
                check("prox_comando", int'(prox_comando), s.prox);
            end
            if (cmd_ack != '0) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", int'(cmd_ack), 0);
                end else begin
                    g = gq.pop_front();
                    check("grant_lane", int'(cmd_ack), 1 << g.lane);
                    check("grant_cmd", int'(prox_comando), g.cmd);
                end
            end
        end
    end

    initial begin
        int r;
        m_prev = -1; m_len = 0;
        for (int i = 0; i < LD; i++) m_list[i] = 0;
        idle_in();
        reset = 1;
        step();
        next_cycle(); reset = 1; step();

        // Basic dispatch of 1,2,3,4 with every lane requesting
        for (int i = 0; i < LD; i++) write_entry(i, (i < 4) ? i + 1 : int'($urandom_range(0, 15)));
        do_start(4);
        hold_trocar(8);
        settle();
        check("go_estado", int'(estado), 2);
        check("go_flag", int'(fim_de_jogo), 1);

        // Nine single hits: multiplier steps to x2 on the ninth
        do_start(16);
        for (int i = 0; i < 9; i++) begin
            hit(1 << $urandom_range(0, N - 1), 0);
            settle();
        end
        check("hits9_score", int'(score), 10);
        check("hits9_combo", int'(combo), 9);

        // Hit and miss in the same cycle
        hit(3'b011, 3'b100);
        settle();
        check("miss_score", int'(score), 14);
        check("miss_combo", int'(combo), 0);

        // Writes while playing must be dropped
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            cmd_wr_en = 1; cmd_wr_addr = AW'(i); cmd_wr_data = 4'hF;
            step();
        end
        hold_trocar(20);
        settle();
        check("drain_estado", int'(estado), 2);
        do_start(4);
        hold_trocar(8);

        // Reset mid-game beats start, write and hits in the same cycle
        do_start(16);
        for (int i = 0; i < 9; i++) hit(3'b001, 0);
        settle();
        check("pre_reset_score", int'(score), 10);
        next_cycle();
        reset = 1; start = 1; fim_da_lista = 5'd5; cmd_wr_en = 1;
        cmd_wr_addr = '0; cmd_wr_data = 4'd7; ponto = '1; trocar = '1;
        step();
        settle();
        check("rst_estado", int'(estado), 0);
        check("rst_score", int'(score), 0);
        check("rst_ack", int'(cmd_ack), 0);
        do_start(0);
        settle();
        check("start0_estado", int'(estado), 0);

        // Score saturation with the multiplier at x4
        do_start(16);
        hit(3'b001, 3'b001);
        hit(3'b010, 3'b010);
        for (int i = 0; i < 24; i++) hit(3'b001, 0);
        settle();
        check("sat_pre_score", int'(score), 50);
        check("sat_pre_combo", int'(combo), 24);
        while (m_score + 12 <= SMAX - 1) hit(3'b111, 0);
        while (m_score + 4 <= SMAX - 1) hit(3'b001, 0);
        settle();
        check("sat_near_max", int'(score), SMAX - 1);
        hit(3'b001, 0);
        settle();
        check("sat_max", int'(score), SMAX);
        hit(3'b111, 0);
        settle();
        check("sat_hold", int'(score), SMAX);
        check("combo_sat", int'(combo), CMAX);

        // Randomized sessions
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            trocar = N'($urandom);
            if ($urandom_range(0, 3) == 0) ponto = N'($urandom);
            if ($urandom_range(0, 9) == 0) erro = N'($urandom);
            r = int'($urandom_range(0, 9));
            if (m_st != 1) begin
                if (r < 4) begin
                    cmd_wr_en = 1; cmd_wr_addr = AW'($urandom); cmd_wr_data = CW'($urandom);
                end else if (r < 6) begin
                    start = 1; fim_da_lista = (AW+1)'($urandom);
                end
            end else begin
                if ($urandom_range(0, 15) == 0) begin
                    cmd_wr_en = 1; cmd_wr_addr = AW'($urandom); cmd_wr_data = CW'($urandom);
                end
                if ($urandom_range(0, 15) == 0) begin
                    start = 1; fim_da_lista = (AW+1)'($urandom);
                end
            end
            if ($urandom_range(0, 199) == 0) reset = 1;
            step();
        end
        settle();

        @(posedge CLOCK_25);
        #2;
        check("status_drained", sq.size(), 0);
        check("grants_drained", gq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
